proc_core_p: RTL and testbench

- Parametrised, multicycle accumulator-style processor core. It fetches 16-bit instructions from an external asynchronous instruction ROM, executes them against an internal register file, and drives a registered output port.
- The external `step` enable replaces a hard-coded clock divider, so board-level slowing is done outside the core.
- Adds real reset, true ADDI, logic ops, BNZ, HALT and a result-valid strobe.

---
 rtl/proc_core_p_pkg.sv | 39 +++
 rtl/proc_core_p_if.sv | 14 +
 rtl/proc_core_p_regfile.sv | 35 +++
 rtl/proc_core_p.sv | 116 +++++++++++
 tb/tb_proc_core_p.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/proc_core_p_pkg.sv
// proc_pkg: shared definitions for the proc_core_p accumulator core.
//   - opcode values (instruction bits [15:12])
//   - FSM state encoding
//   - bit positions of the instruction fields
//   - op_of(): extracts the opcode from a 16-bit instruction word
package proc_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_BZ   = 4'b1100;
    localparam logic [3:0] OP_BNZ  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1110;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Instruction field positions. The rb field overlaps the upper bits of
    // imm8 and the target field; each opcode uses only the fields it needs.
    localparam int OP_LSB  = 12;
    localparam int RA_LSB  = 9;
    localparam int RB_LSB  = 6;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 8;
    localparam int TGT_LSB = 8;

    function automatic logic [3:0] op_of(input logic [15:0] instr);
        return instr[OP_LSB +: 4];
    endfunction

endpackage

// File: rtl/proc_core_p_if.sv
// proc_core_p_if: instruction-ROM bus between the core and an external
// asynchronous ROM.
//   address     - program counter driven by the core
//   instruction - ROM word at address, combinational from address
// Modports: master = core side, slave = ROM side.
interface proc_core_p_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic [15:0]       instruction;

    modport master (output address, input instruction);
    modport slave  (input address, output instruction);
endinterface

// File: rtl/proc_core_p_regfile.sv
// proc_regfile_p: 2**REG_AW x DATA_W register file.
//   clk, rst                 - clock, synchronous active-high clear
//   we, wr_addr, wr_data     - synchronous write port
//   rd_addr_a/b, rd_data_a/b - two asynchronous read ports
// Reads return the pre-write contents during a write cycle, so an
// instruction may name the same register as source and destination.
module proc_regfile_p #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);
    logic [DATA_W-1:0] regs [2**REG_AW];

    // NOTE: the array is cleared on reset, so it maps to flops rather than a
    // RAM macro; a RAM-backed file would have to drop the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
endmodule

// File: rtl/proc_core_p.sv
// proc_core_p: multicycle accumulator-style core. Each instruction takes
// two step-enabled cycles (FETCH, EXEC); HALT is left only through rst.
//   clk, rst     - clock, synchronous active-high reset
//   step         - advance enable; the FSM moves only when step=1
//   rom          - ROM bus (address out, instruction in)
//   result       - value of the last OUT, registered
//   result_valid - one-cycle pulse on the edge that updates result
//   zero         - zero flag from the last ADDI/ADD/SUB/AND/OR
//   halted       - high while in the HALT state
// REG_AW is fixed at 3 by the instruction encoding.
module proc_core_p
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int REG_AW = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    proc_core_p_if.master       rom,
    output logic [DATA_W-1:0]   result,
    output logic                result_valid,
    output logic                zero,
    output logic                halted
);
    state_t              state, next_state;
    logic [15:0]         ir;
    logic [ADDR_W-1:0]   pc;
    logic [3:0]          op;
    logic [REG_AW-1:0]   ra_idx, rb_idx;
    logic [ADDR_W-1:0]   tgt;
    logic signed [IMM_W-1:0] imm8;
    logic [DATA_W-1:0]   ra_val, rb_val, alu_res;
    logic                wr_en, branch, exec_fire;

    assign op        = op_of(ir);
    assign ra_idx    = ir[RA_LSB +: REG_AW];
    assign rb_idx    = ir[RB_LSB +: REG_AW];
    assign tgt       = ir[TGT_LSB +: ADDR_W];
    assign imm8      = ir[IMM_LSB +: IMM_W];
    assign exec_fire = step && (state == ST_EXEC);
    assign halted    = (state == ST_HALT);
    assign rom.address = pc;

    proc_regfile_p #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (wr_en && exec_fire),
        .wr_addr   (ra_idx),
        .wr_data   (alu_res),
        .rd_addr_a (ra_idx),
        .rd_data_a (ra_val),
        .rd_addr_b (rb_idx),
        .rd_data_b (rb_val)
    );

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        alu_res = '0;
        wr_en   = 1'b0;
        branch  = 1'b0;
        case (op)
            OP_ADDI: begin alu_res = ra_val + DATA_W'(imm8); wr_en = 1'b1; end
            OP_ADD:  begin alu_res = ra_val + rb_val;        wr_en = 1'b1; end
            OP_SUB:  begin alu_res = ra_val - rb_val;        wr_en = 1'b1; end
            OP_AND:  begin alu_res = ra_val & rb_val;        wr_en = 1'b1; end
            OP_OR:   begin alu_res = ra_val | rb_val;        wr_en = 1'b1; end
            OP_JMP:  branch = 1'b1;
            OP_BZ:   branch = zero;
            OP_BNZ:  branch = !zero;
            default: ;  // NOP, HALT, OUT and undefined opcodes write nothing
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH: if (step) next_state = ST_EXEC;
            ST_EXEC:  if (step) next_state = (op == OP_HALT) ? ST_HALT : ST_FETCH;
            ST_HALT:  next_state = ST_HALT;
            default:  next_state = ST_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_FETCH;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            ir           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            zero         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (step && state == ST_FETCH) ir <= rom.instruction;
            if (exec_fire) begin
                if (wr_en) zero <= (alu_res == '0);
                if (op == OP_OUT) begin
                    result       <= ra_val;
                    result_valid <= 1'b1;
                end
                // HALT keeps the PC on the HALT instruction itself.
                if (branch)              pc <= tgt;
                else if (op != OP_HALT)  pc <= pc + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_proc_core_p.sv
// tb_proc_core_p: directed self-checking bench for proc_core_p
// (DATA_W=16, ADDR_W=4). The ROM is a bench array read combinationally
// from the core's address.
module tb_proc_core_p;
    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic [15:0] result;
    logic        result_valid, zero, halted;
    logic [15:0] rom_mem [16];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rv_count = 0;
    int rv_cycle = 0;

    always #5 clk = ~clk;

    proc_core_p_if #(.ADDR_W(4)) rom_bus ();
    assign rom_bus.instruction = rom_mem[rom_bus.address];

    proc_core_p #(.DATA_W(16), .ADDR_W(4), .REG_AW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .step         (step),
        .rom          (rom_bus),
        .result       (result),
        .result_valid (result_valid),
        .zero         (zero),
        .halted       (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance n edges; outputs are sampled 1 time unit after each edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (result_valid) begin
                rv_count++;
                rv_cycle = cyc;
            end
        end
    endtask

    task automatic load_nops();
        for (int i = 0; i < 16; i++) rom_mem[i] = 16'h0000;
    endtask

    task automatic do_reset(input int n);
        rst  = 1'b1;
        step = 1'b1;
        tick(n);
        rst      = 1'b0;
        cyc      = 0;
        rv_count = 0;
        rv_cycle = 0;
    endtask

    function automatic logic [15:0] enc_addi(input logic [2:0] ra, input logic [7:0] imm);
        return {4'h1, ra, 1'b0, imm};
    endfunction
    function automatic logic [15:0] enc_rr(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb);
        return {op, ra, rb, 6'b0};
    endfunction
    function automatic logic [15:0] enc_br(input logic [3:0] op, input logic [3:0] tgt);
        return {op, tgt, 8'h00};
    endfunction
    function automatic logic [15:0] enc_out(input logic [2:0] ra);
        return {4'hF, ra, 9'b0};
    endfunction

    initial begin
        rst  = 1'b1;
        step = 1'b0;
        load_nops();
        #1;

        // 1. reset with step=1, then idle with step=0
        rst = 1'b1; step = 1'b1; rv_count = 0;
        tick(2);
        rst = 1'b0; step = 1'b0;
        tick(10);
        check("rst_address", 32'(rom_bus.address), 32'h0);
        check("rst_result",  32'(result), 32'h0);
        check("rst_zero",    32'(zero), 32'h0);
        check("rst_halted",  32'(halted), 32'h0);
        check("rst_rv_seen", 32'(rv_count), 32'h0);

        // 2. ADDI with sign extension and OUT
        load_nops();
        rom_mem[0] = enc_addi(3'd1, 8'h05);
        rom_mem[1] = enc_addi(3'd1, 8'hFD);
        rom_mem[2] = enc_out(3'd1);
        do_reset(1);
        tick(6);
        check("addi_rv_now",   32'(result_valid), 32'h1);
        check("addi_rv_cycle", 32'(rv_cycle), 32'd6);
        check("addi_result",   32'(result), 32'h0002);
        check("addi_zero",     32'(zero), 32'h0);
        step = 1'b0;
        tick(1);
        check("stall_rv",      32'(result_valid), 32'h0);
        check("stall_address", 32'(rom_bus.address), 32'h3);
        step = 1'b1;
        tick(4);
        check("addi_rv_once",  32'(rv_count), 32'd1);

        // 3a. SUB to zero, BZ taken
        load_nops();
        rom_mem[0] = enc_addi(3'd2, 8'd7);
        rom_mem[1] = enc_addi(3'd3, 8'd7);
        rom_mem[2] = enc_rr(4'h3, 3'd2, 3'd3);
        rom_mem[3] = enc_br(4'hC, 4'd9);
        do_reset(1);
        tick(6);
        check("sub_zero",      32'(zero), 32'h1);
        check("sub_address",   32'(rom_bus.address), 32'h3);
        tick(2);
        check("bz_taken_addr", 32'(rom_bus.address), 32'h9);
        check("bz_taken_zero", 32'(zero), 32'h1);

        // 3b. SUB nonzero, BZ not taken
        rom_mem[1] = enc_addi(3'd3, 8'd6);
        do_reset(1);
        tick(8);
        check("bz_nt_zero",    32'(zero), 32'h0);
        check("bz_nt_addr",    32'(rom_bus.address), 32'h4);

        // 3c. AND / OR and BNZ
        load_nops();
        rom_mem[0] = enc_addi(3'd6, 8'h0C);
        rom_mem[1] = enc_addi(3'd7, 8'h0A);
        rom_mem[2] = enc_rr(4'h4, 3'd6, 3'd7);
        rom_mem[3] = enc_out(3'd6);
        rom_mem[4] = enc_rr(4'h5, 3'd6, 3'd7);
        rom_mem[5] = enc_out(3'd6);
        rom_mem[6] = enc_br(4'hD, 4'd12);
        do_reset(1);
        tick(8);
        check("and_result",    32'(result), 32'h0008);
        tick(4);
        check("or_result",     32'(result), 32'h000A);
        tick(2);
        check("bnz_taken",     32'(rom_bus.address), 32'hC);

        // 4a. build 0x7FFF, then ADD r1,r1 overflows to 0xFFFE
        load_nops();
        rom_mem[0] = enc_addi(3'd1, 8'h40);
        for (int i = 1; i <= 9; i++) rom_mem[i] = enc_rr(4'h2, 3'd1, 3'd1);
        rom_mem[10] = enc_addi(3'd1, 8'hFF);
        rom_mem[11] = enc_out(3'd1);
        rom_mem[12] = enc_rr(4'h2, 3'd1, 3'd1);
        rom_mem[13] = enc_out(3'd1);
        do_reset(1);
        tick(24);
        check("ovf_pre",       32'(result), 32'h7FFF);
        tick(4);
        check("ovf_double",    32'(result), 32'hFFFE);
        check("ovf_zero",      32'(zero), 32'h0);

        // 4b. PC wrap through NOPs from entry 7
        load_nops();
        rom_mem[0] = enc_br(4'h8, 4'd7);
        do_reset(1);
        tick(2);
        check("jmp_address",   32'(rom_bus.address), 32'h7);
        tick(16);
        check("wrap_pre",      32'(rom_bus.address), 32'hF);
        tick(2);
        check("wrap_address",  32'(rom_bus.address), 32'h0);

        // 5. HALT ignores step; only rst leaves it
        load_nops();
        rom_mem[0] = enc_out(3'd0);
        rom_mem[1] = 16'hE000;
        do_reset(1);
        tick(2);
        check("out_r0_rv",     32'(result_valid), 32'h1);
        check("out_r0_val",    32'(result), 32'h0);
        tick(2);
        check("halt_flag",     32'(halted), 32'h1);
        check("halt_address",  32'(rom_bus.address), 32'h1);
        rv_count = 0;
        for (int i = 0; i < 50; i++) begin
            step = 1'($urandom_range(0, 1));
            tick(1);
        end
        check("halt_no_rv",    32'(rv_count), 32'h0);
        check("halt_hold_adr", 32'(rom_bus.address), 32'h1);
        check("halt_hold_flg", 32'(halted), 32'h1);
        rst = 1'b1; step = 1'b0;
        tick(1);
        rst = 1'b0;
        check("halt_rst_flag", 32'(halted), 32'h0);
        check("halt_rst_addr", 32'(rom_bus.address), 32'h0);

        // 6. reset on the EXEC edge of ADDI r4,#1
        load_nops();
        rom_mem[0] = enc_addi(3'd4, 8'd1);
        do_reset(1);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_addr",   32'(rom_bus.address), 32'h0);
        check("midrst_zero",   32'(zero), 32'h0);
        rom_mem[0] = enc_out(3'd4);
        rv_count = 0;
        tick(2);
        check("midrst_rv",     32'(result_valid), 32'h1);
        check("midrst_r4",     32'(result), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
